// File: rtl/lcm_serial_controller_pkg.sv
// Shared types and constants for the TRDB LCM 3-wire serial engine.
// The state enum, idle pin levels and request priority live here.
package lcm_serial_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        BIT_LOW  = 3'd2,
        BIT_HIGH = 3'd3,
        STOP     = 3'd4,
        COMPLETE = 3'd5,
        ACK_LOW  = 3'd6,
        ACK_HIGH = 3'd7
    } state_t;

    localparam logic SCEN_IDLE = 1'b1;
    localparam logic SCLK_IDLE = 1'b1;
    localparam logic SDAT_IDLE = 1'b1;

    // Encoded in priority order: start beats transfer beats stop.
    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_START = 2'd1,
        REQ_XFER  = 2'd2,
        REQ_STOP  = 2'd3
    } req_t;

    function automatic req_t req_select(input logic start, input logic xfer, input logic stop);
        if (start)     return REQ_START;
        else if (xfer) return REQ_XFER;
        else if (stop) return REQ_STOP;
        else           return REQ_NONE;
    endfunction

endpackage

// File: rtl/lcm_serial_controller_if.sv
// Request/complete handshake between a command source (master) and the
// serial engine (slave).
interface lcm_serial_controller_if;
    logic       send_start_bit;
    logic       transfer_data;
    logic       send_stop_bit;
    logic [7:0] data_in;
    logic [2:0] data_size;
    logic       transfer_complete;
    logic       ack;

    modport master (
        output send_start_bit, transfer_data, send_stop_bit, data_in, data_size,
        input  transfer_complete, ack
    );

    modport slave (
        input  send_start_bit, transfer_data, send_stop_bit, data_in, data_size,
        output transfer_complete, ack
    );
endinterface

// File: rtl/lcm_serial_clk_div.sv
// SCLK half-period divider: counts 0..CLK_DIV-1 while enabled and pulses
// tick on the terminal count; clr restarts the period on a state change.
module lcm_serial_clk_div #(
    parameter int CLK_DIV = 250,
    parameter int CNT_W   = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_reg <= '0;
        else if (clr || !en || cnt_reg == TERM)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end

    // Independent of clr so the FSM can use tick to decide its next state.
    assign tick = en && (cnt_reg == TERM);
endmodule

// File: rtl/lcm_serial_controller.sv
// Bit-level SCEN/SCLK/SDAT engine for the TRDB LCM control port.
// Define LCM_SERIAL_ACK_EN to add the ninth-clock acknowledge slot.
module lcm_serial_controller
    import lcm_serial_pkg::*;
#(
    parameter int CLK_DIV = 250,
    parameter int CNT_W   = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    lcm_serial_controller_if.slave  req,
    input  logic                    sdat_in,
    output logic                    sclk,
    output logic                    sdat_out,
    output logic                    sdat_oe,
    output logic                    scen
);
    state_t     state_reg, state_next;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx_reg;
    logic       scen_reg;
    logic       tick;
    logic       latch_xfer;
    logic       dec_idx;
    logic       sample_ack;
    logic       any_req;

    assign any_req = req.send_start_bit || req.transfer_data || req.send_stop_bit;

    lcm_serial_clk_div #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) u_clk_div (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_reg != IDLE && state_reg != COMPLETE),
        .clr     (state_next != state_reg),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        latch_xfer = 1'b0;
        dec_idx    = 1'b0;
        sample_ack = 1'b0;
        case (state_reg)
            IDLE: begin
                case (req_select(req.send_start_bit, req.transfer_data, req.send_stop_bit))
                    REQ_START: state_next = START;
                    REQ_XFER: begin
                        state_next = BIT_LOW;
                        latch_xfer = 1'b1;
                    end
                    REQ_STOP:  state_next = STOP;
                    default:   state_next = IDLE;
                endcase
            end
            START, STOP: if (tick) state_next = COMPLETE;
            BIT_LOW:     if (tick) state_next = BIT_HIGH;
            BIT_HIGH: begin
                if (tick) begin
                    if (bit_idx_reg == 3'd0) begin
`ifdef LCM_SERIAL_ACK_EN
                        state_next = ACK_LOW;
`else
                        state_next = COMPLETE;
`endif
                    end else begin
                        state_next = BIT_LOW;
                        dec_idx    = 1'b1;
                    end
                end
            end
`ifdef LCM_SERIAL_ACK_EN
            ACK_LOW:  if (tick) state_next = ACK_HIGH;
            ACK_HIGH: begin
                if (tick) begin
                    state_next = COMPLETE;
                    sample_ack = 1'b1;
                end
            end
`endif
            COMPLETE: if (!any_req) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            scen_reg    <= SCEN_IDLE;
        end else begin
            if (latch_xfer) begin
                shift_reg   <= req.data_in;
                bit_idx_reg <= req.data_size;
            end else if (dec_idx) begin
                bit_idx_reg <= bit_idx_reg - 3'd1;
            end
            if (state_reg == IDLE && state_next == START)
                scen_reg <= 1'b0;
            else if (state_reg == IDLE && state_next == STOP)
                scen_reg <= SCEN_IDLE;
        end
    end

    // Pins decode straight from state so an async reset idles them at once.
    assign scen     = scen_reg;
    assign sclk     = (state_reg == BIT_LOW || state_reg == ACK_LOW) ? 1'b0 : SCLK_IDLE;
    assign sdat_out = (state_reg == BIT_LOW || state_reg == BIT_HIGH) ? shift_reg[bit_idx_reg] : SDAT_IDLE;
    assign req.transfer_complete = (state_reg == COMPLETE);

`ifdef LCM_SERIAL_ACK_EN
    logic ack_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ack_reg <= 1'b0;
        else if (latch_xfer)
            ack_reg <= 1'b0;
        else if (sample_ack)
            ack_reg <= sdat_in;
    end

    assign req.ack = ack_reg;
    assign sdat_oe = !(state_reg == ACK_LOW || state_reg == ACK_HIGH);
`else
    logic unused_ack_inputs;
    assign unused_ack_inputs = sdat_in ^ sample_ack;
    assign req.ack = 1'b0;
    assign sdat_oe = 1'b1;
`endif
endmodule

// File: tb/tb_lcm_serial_controller.sv
// Directed bench for lcm_serial_controller at CLK_DIV=4; covers the
// default build and the LCM_SERIAL_ACK_EN build.
module tb_lcm_serial_controller;
    import lcm_serial_pkg::*;

    localparam int CLK_DIV = 4;
`ifdef LCM_SERIAL_ACK_EN
    localparam int ACK_ON = 1;
`else
    localparam int ACK_ON = 0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic sdat_in = 1'b0;
    logic sclk, sdat_out, sdat_oe, scen;

    lcm_serial_controller_if bus ();

    lcm_serial_controller #(.CLK_DIV(CLK_DIV), .CNT_W(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (bus),
        .sdat_in  (sdat_in),
        .sclk     (sclk),
        .sdat_out (sdat_out),
        .sdat_oe  (sdat_oe),
        .scen     (scen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Results of the last run_op
    int r_n, r_edges, r_bit_err, r_oe_low;
    logic r_ack1, r_scen1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        bus.send_start_bit = 1'b0;
        bus.transfer_data  = 1'b0;
        bus.send_stop_bit  = 1'b0;
    endtask

    // Raise a request and watch the pins until transfer_complete rises.
    // r_n counts cycles from the request being raised; accept is at r_n=1.
    task automatic run_op(input bit st, input bit xf, input bit sp,
                          input logic [7:0] data, input logic [2:0] size, input logic sd);
        int   idx;
        logic prev_sclk;
        bus.send_start_bit = st;
        bus.transfer_data  = xf;
        bus.send_stop_bit  = sp;
        bus.data_in        = data;
        bus.data_size      = size;
        sdat_in            = sd;
        r_n = 0; r_edges = 0; r_bit_err = 0; r_oe_low = 0;
        r_ack1 = 1'bx; r_scen1 = 1'bx;
        idx = int'(size);
        prev_sclk = sclk;
        while (bus.transfer_complete !== 1'b1 && r_n < 400) begin
            step();
            r_n++;
            if (r_n == 1) begin
                r_ack1  = bus.ack;
                r_scen1 = scen;
            end
            if (r_n == 2) begin
                bus.data_in   = ~data;
                bus.data_size = ~size;
            end
            if (sdat_oe === 1'b0) r_oe_low++;
            if (prev_sclk === 1'b0 && sclk === 1'b1 && sdat_oe === 1'b1) begin
                r_edges++;
                if (idx < 0 || sdat_out !== data[idx]) r_bit_err++;
                idx--;
            end
            prev_sclk = sclk;
        end
    endtask

    typedef struct {
        bit         start;
        bit         xfer;
        bit         stop;
        logic [7:0] data;
        logic [2:0] size;
        logic       sdat;
        int         cycles;   // without the ack slot
        logic       scen_after;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   exp_cycles;
        int   hold_ok;
        int   found;
        int   edges;
        logic prev;

        // start, addr 0x08/7 bits, data 0x3F/8 bits, 1-bit, stop, stray stop, unframed transfer
        vecs[0] = '{1, 0, 0, 8'h00, 3'd0, 1'b0,  5, 1'b0};
        vecs[1] = '{0, 1, 0, 8'h08, 3'd6, 1'b0, 57, 1'b0};
        vecs[2] = '{0, 1, 0, 8'h3F, 3'd7, 1'b1, 65, 1'b0};
        vecs[3] = '{0, 1, 0, 8'hA5, 3'd0, 1'b0,  9, 1'b0};
        vecs[4] = '{0, 0, 1, 8'h00, 3'd0, 1'b0,  5, 1'b1};
        vecs[5] = '{0, 0, 1, 8'h00, 3'd0, 1'b0,  5, 1'b1};
        vecs[6] = '{0, 1, 0, 8'hC3, 3'd3, 1'b1, 33, 1'b1};

        drop_reqs();
        bus.data_in   = 8'h00;
        bus.data_size = 3'd0;

        #2 reset_n = 1'b0;
        #1;
        check("reset_scen", scen, 1);
        check("reset_sclk", sclk, 1);
        check("reset_sdat_out", sdat_out, 1);
        check("reset_sdat_oe", sdat_oe, 1);
        check("reset_complete", bus.transfer_complete, 0);
        check("reset_ack", bus.ack, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            exp_cycles = vecs[i].cycles + (vecs[i].xfer ? ACK_ON * 2 * CLK_DIV : 0);
            run_op(vecs[i].start, vecs[i].xfer, vecs[i].stop, vecs[i].data, vecs[i].size, vecs[i].sdat);
            check($sformatf("v%0d_cycles", i), r_n, exp_cycles);
            check($sformatf("v%0d_sclk_edges", i), r_edges, vecs[i].xfer ? int'(vecs[i].size) + 1 : 0);
            check($sformatf("v%0d_sdat_bit_errors", i), r_bit_err, 0);
            check($sformatf("v%0d_oe_low_cycles", i), r_oe_low, (vecs[i].xfer && ACK_ON == 1) ? 2 * CLK_DIV : 0);
            check($sformatf("v%0d_scen", i), scen, int'(vecs[i].scen_after));
            if (vecs[i].start)
                check($sformatf("v%0d_scen_next_cycle", i), r_scen1, 0);
            if (vecs[i].xfer) begin
                check($sformatf("v%0d_ack_cleared_at_accept", i), r_ack1, 0);
                check($sformatf("v%0d_ack", i), bus.ack, ACK_ON == 1 ? int'(vecs[i].sdat) : 0);
            end
            step();
            check($sformatf("v%0d_complete_held", i), bus.transfer_complete, 1);
            drop_reqs();
            step();
            check($sformatf("v%0d_complete_drop", i), bus.transfer_complete, 0);
            check($sformatf("v%0d_idle_sclk", i), sclk, 1);
            check($sformatf("v%0d_idle_sdat", i), sdat_out, 1);
            step();
        end

        // Start and transfer together: start wins, transfer waits behind complete.
        run_op(1, 1, 0, 8'hFF, 3'd7, 1'b0);
        check("simul_cycles", r_n, 5);
        check("simul_scen", scen, 0);
        hold_ok = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.transfer_complete === 1'b1 && sclk === 1'b1) hold_ok++;
        end
        check("simul_transfer_not_accepted", hold_ok, 3);
        drop_reqs();
        step();
        check("simul_complete_drop", bus.transfer_complete, 0);
        step();

        // Reset in the low phase of bit 3 of an 8-bit transfer inside an open frame.
        bus.transfer_data = 1'b1;
        bus.data_in       = 8'h00;
        bus.data_size     = 3'd7;
        found = 0;
        edges = 0;
        prev  = sclk;
        for (int k = 0; k < 200 && found == 0; k++) begin
            step();
            if (prev === 1'b0 && sclk === 1'b1) edges++;
            if (edges == 4 && sclk === 1'b0) found = 1;
            prev = sclk;
        end
        check("midreset_reached_bit3", found, 1);
        check("midreset_pre_scen", scen, 0);
        check("midreset_pre_sdat", sdat_out, 0);
        reset_n = 1'b0;
        drop_reqs();
        #1;
        check("midreset_scen", scen, 1);
        check("midreset_sclk", sclk, 1);
        check("midreset_sdat_out", sdat_out, 1);
        check("midreset_complete", bus.transfer_complete, 0);
        step();
        reset_n = 1'b1;
        step();

        run_op(1, 0, 0, 8'h00, 3'd0, 1'b0);
        check("post_reset_start_cycles", r_n, 5);
        check("post_reset_start_scen", scen, 0);
        drop_reqs();
        step();
        check("post_reset_start_drop", bus.transfer_complete, 0);
        step();

        run_op(0, 0, 1, 8'h00, 3'd0, 1'b0);
        check("final_stop_cycles", r_n, 5);
        check("final_stop_scen", scen, 1);
        check("final_stop_sclk", sclk, 1);
        check("final_stop_sdat", sdat_out, 1);
        drop_reqs();
        step();
        check("final_stop_drop", bus.transfer_complete, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
